// File: rtl/rida_pkg.sv
// Shared types and constants for the RIDA memory/writeback stage.
package rida_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] SP_RESET_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/mem_wb_cycle_if.sv
// Data-memory request/acknowledge bus between the M stage and the data memory.
interface mem_wb_cycle_if;

    logic        DMemReq;
    logic        DMemWE;
    logic [31:0] DMemAddr;
    logic [31:0] DMemWData;
    logic [31:0] DMemRData;
    logic        DMemAck;

    modport master (
        output DMemReq, DMemWE, DMemAddr, DMemWData,
        input  DMemRData, DMemAck
    );

    modport slave (
        input  DMemReq, DMemWE, DMemAddr, DMemWData,
        output DMemRData, DMemAck
    );

endinterface

// File: rtl/stack_pointer_unit.sv
// Architectural stack pointer: push/pop address generation, limit checks and
// stack-op fault decode. SP only moves when the owning access completes.
module stack_pointer_unit
    import rida_pkg::*;
#(
    parameter logic [31:0] SP_RESET    = SP_RESET_DEFAULT,
    parameter int unsigned STACK_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_req,
    input  logic        pop_req,
    input  logic        data_op,
    input  logic        push_commit,
    input  logic        pop_commit,
    output logic [31:0] sp,
    output logic [31:0] stack_addr,
    output logic        stack_fault
);

    localparam logic [31:0] SP_FULL = SP_RESET - (WORD_BYTES * 32'(STACK_WORDS));

    logic [31:0] sp_q;
    logic [31:0] sp_d;
    logic        full_s;
    logic        empty_s;

    // Next SP, push/pop address and stack fault decode.
    always_comb begin
        sp_d        = sp_q;
        stack_addr  = sp_q;
        full_s      = (sp_q == SP_FULL);
        empty_s     = (sp_q == SP_RESET);
        if (push_commit) begin
            sp_d = sp_q - WORD_BYTES;
        end else if (pop_commit) begin
            sp_d = sp_q + WORD_BYTES;
        end else begin
            sp_d = sp_q;
        end
        if (push_req) begin
            stack_addr = sp_q - WORD_BYTES;
        end else begin
            stack_addr = sp_q;
        end
        stack_fault = (push_req & pop_req)
                    | ((push_req | pop_req) & data_op)
                    | (push_req & full_s)
                    | (pop_req & empty_s);
    end

    // Stack pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= SP_RESET;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp = sp_q;

endmodule

// File: rtl/mem_wb_cycle.sv
// RIDA memory/writeback stage: issues loads/stores/push/pop on the data-memory
// bus, stalls upstream while an access is outstanding, and drives the W triple.
module mem_wb_cycle
    import rida_pkg::*;
#(
    parameter logic [31:0] SP_RESET    = SP_RESET_DEFAULT,
    parameter int unsigned STACK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidM,
    input  logic                  RegWriteM,
    input  logic                  ResultSrcM,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic                  PushM,
    input  logic                  PopM,
    input  logic [4:0]            RDM,
    input  logic [31:0]           ALUResultM,
    input  logic [31:0]           WriteDataM,
    output logic                  StallM,
    mem_wb_cycle_if.master        dmem,
    output logic                  RegWriteW,
    output logic [4:0]            RDW,
    output logic [31:0]           ResultW,
    output logic [31:0]           SPOut,
    output logic                  StackFaultW
);

    mem_state_t  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        regwrite_w_q, regwrite_w_d;
    logic [4:0]  rd_w_q, rd_w_d;
    logic [31:0] result_w_q, result_w_d;
    logic        fault_q, fault_d;
    logic [4:0]  cap_rd_q, cap_rd_d;
    logic        cap_regwrite_q, cap_regwrite_d;
    logic        cap_resultsrc_q, cap_resultsrc_d;
    logic        cap_push_q, cap_push_d;
    logic        cap_pop_q, cap_pop_d;
    logic [31:0] cap_alu_q, cap_alu_d;

    logic        mem_op_s;
    logic        stack_fault_s;
    logic        op_fault_s;
    logic        ack_done_s;
    logic [31:0] stack_addr_s;

    assign mem_op_s   = ValidM & (MemReadM | MemWriteM | PushM | PopM);
    assign op_fault_s = stack_fault_s | (ValidM & MemReadM & MemWriteM);
    // Ack is only meaningful while a request is outstanding.
    assign ack_done_s = (state_q == ACCESS) & dmem.DMemAck;

    stack_pointer_unit #(
        .SP_RESET    (SP_RESET),
        .STACK_WORDS (STACK_WORDS)
    ) u_spu (
        .clk         (clk),
        .rst         (rst),
        .push_req    (ValidM & PushM),
        .pop_req     (ValidM & PopM),
        .data_op     (MemReadM | MemWriteM),
        .push_commit (ack_done_s & cap_push_q),
        .pop_commit  (ack_done_s & cap_pop_q),
        .sp          (SPOut),
        .stack_addr  (stack_addr_s),
        .stack_fault (stack_fault_s)
    );

    // Next-state and output decode for the IDLE/ACCESS sequencer.
    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        regwrite_w_d    = 1'b0;
        rd_w_d          = rd_w_q;
        result_w_d      = result_w_q;
        fault_d         = 1'b0;
        cap_rd_d        = cap_rd_q;
        cap_regwrite_d  = cap_regwrite_q;
        cap_resultsrc_d = cap_resultsrc_q;
        cap_push_d      = cap_push_q;
        cap_pop_d       = cap_pop_q;
        cap_alu_d       = cap_alu_q;
        case (state_q)
            IDLE: begin
                if (mem_op_s && op_fault_s) begin
                    fault_d = 1'b1;
                end else if (mem_op_s) begin
                    state_d         = ACCESS;
                    req_d           = 1'b1;
                    we_d            = MemWriteM | PushM;
                    wdata_d         = WriteDataM;
                    cap_rd_d        = RDM;
                    cap_regwrite_d  = RegWriteM;
                    cap_resultsrc_d = ResultSrcM;
                    cap_push_d      = PushM;
                    cap_pop_d       = PopM;
                    cap_alu_d       = ALUResultM;
                    if (PushM || PopM) begin
                        addr_d = stack_addr_s;
                    end else begin
                        addr_d = ALUResultM;
                    end
                end else if (ValidM) begin
                    regwrite_w_d = RegWriteM;
                    rd_w_d       = RDM;
                    result_w_d   = ALUResultM;
                end else begin
                    regwrite_w_d = 1'b0;
                end
            end
            ACCESS: begin
                if (dmem.DMemAck) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    rd_w_d  = cap_rd_q;
                    if (cap_pop_q) begin
                        regwrite_w_d = 1'b1;
                    end else if (cap_push_q) begin
                        regwrite_w_d = 1'b0;
                    end else begin
                        regwrite_w_d = cap_regwrite_q;
                    end
                    if (cap_pop_q || cap_resultsrc_q) begin
                        result_w_d = dmem.DMemRData;
                    end else begin
                        result_w_d = cap_alu_q;
                    end
                end else begin
                    regwrite_w_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // Sequencer state, bus and writeback registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= 32'h0000_0000;
            wdata_q         <= 32'h0000_0000;
            regwrite_w_q    <= 1'b0;
            rd_w_q          <= 5'd0;
            result_w_q      <= 32'h0000_0000;
            fault_q         <= 1'b0;
            cap_rd_q        <= 5'd0;
            cap_regwrite_q  <= 1'b0;
            cap_resultsrc_q <= 1'b0;
            cap_push_q      <= 1'b0;
            cap_pop_q       <= 1'b0;
            cap_alu_q       <= 32'h0000_0000;
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            regwrite_w_q    <= regwrite_w_d;
            rd_w_q          <= rd_w_d;
            result_w_q      <= result_w_d;
            fault_q         <= fault_d;
            cap_rd_q        <= cap_rd_d;
            cap_regwrite_q  <= cap_regwrite_d;
            cap_resultsrc_q <= cap_resultsrc_d;
            cap_push_q      <= cap_push_d;
            cap_pop_q       <= cap_pop_d;
            cap_alu_q       <= cap_alu_d;
        end
    end

    assign StallM         = (state_q == ACCESS);
    assign dmem.DMemReq   = req_q;
    assign dmem.DMemWE    = we_q;
    assign dmem.DMemAddr  = addr_q;
    assign dmem.DMemWData = wdata_q;
    assign RegWriteW      = regwrite_w_q;
    assign RDW            = rd_w_q;
    assign ResultW        = result_w_q;
    assign StackFaultW    = fault_q;

endmodule

// File: tb/tb_mem_wb_cycle.sv
// Directed bench for mem_wb_cycle with a two-word stack so the full limit is reachable.
module tb_mem_wb_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM, RegWriteM, ResultSrcM, MemReadM, MemWriteM, PushM, PopM;
    logic [4:0]  RDM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM, RegWriteW, StackFaultW;
    logic [4:0]  RDW;
    logic [31:0] ResultW, SPOut;
    int          n_checks = 0;
    int          n_errors = 0;

    mem_wb_cycle_if dmem_if ();

    mem_wb_cycle #(
        .SP_RESET    (32'h0000_1000),
        .STACK_WORDS (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ValidM      (ValidM),
        .RegWriteM   (RegWriteM),
        .ResultSrcM  (ResultSrcM),
        .MemReadM    (MemReadM),
        .MemWriteM   (MemWriteM),
        .PushM       (PushM),
        .PopM        (PopM),
        .RDM         (RDM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .StallM      (StallM),
        .dmem        (dmem_if.master),
        .RegWriteW   (RegWriteW),
        .RDW         (RDW),
        .ResultW     (ResultW),
        .SPOut       (SPOut),
        .StackFaultW (StackFaultW)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_m();
        ValidM = 1'b0; RegWriteM = 1'b0; ResultSrcM = 1'b0; MemReadM = 1'b0;
        MemWriteM = 1'b0; PushM = 1'b0; PopM = 1'b0; RDM = 5'd0;
        ALUResultM = 32'h0; WriteDataM = 32'h0;
    endtask

    // Runs one access already presented on the M inputs; ack arrives after nwait waiting cycles.
    task automatic mem_txn(input string tag, input logic [31:0] exp_addr, input logic exp_we,
                           input logic [31:0] exp_wdata, input logic [31:0] rdata, input int nwait);
        for (int i = 0; i <= nwait; i++) begin
            step();
            check_eq({tag, "_stall"}, StallM, 32'd1);
            check_eq({tag, "_req"}, dmem_if.DMemReq, 32'd1);
            check_eq({tag, "_addr"}, dmem_if.DMemAddr, exp_addr);
            check_eq({tag, "_we"}, dmem_if.DMemWE, exp_we);
            check_eq({tag, "_wbusy"}, RegWriteW, 32'd0);
            if (exp_we) check_eq({tag, "_wdata"}, dmem_if.DMemWData, exp_wdata);
            if (i == nwait) begin
                dmem_if.DMemAck   = 1'b1;
                dmem_if.DMemRData = rdata;
            end
        end
        step();
        dmem_if.DMemAck   = 1'b0;
        dmem_if.DMemRData = 32'h0;
        clear_m();
        check_eq({tag, "_stall_end"}, StallM, 32'd0);
        check_eq({tag, "_req_end"}, dmem_if.DMemReq, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        clear_m();
        dmem_if.DMemAck   = 1'b0;
        dmem_if.DMemRData = 32'h0;
        step();
        step();
        check_eq("rst_stall", StallM, 32'd0);
        check_eq("rst_req", dmem_if.DMemReq, 32'd0);
        check_eq("rst_we", dmem_if.DMemWE, 32'd0);
        check_eq("rst_addr", dmem_if.DMemAddr, 32'h0);
        check_eq("rst_wdata", dmem_if.DMemWData, 32'h0);
        check_eq("rst_regw", RegWriteW, 32'd0);
        check_eq("rst_rdw", RDW, 32'd0);
        check_eq("rst_resw", ResultW, 32'h0);
        check_eq("rst_fault", StackFaultW, 32'd0);
        check_eq("rst_sp", SPOut, 32'h0000_1000);
        rst = 1'b0;

        // ALU op, then a bubble
        ValidM = 1'b1; RegWriteM = 1'b1; RDM = 5'd3; ALUResultM = 32'h0000_1234;
        step();
        clear_m();
        check_eq("alu_regw", RegWriteW, 32'd1);
        check_eq("alu_rdw", RDW, 32'd3);
        check_eq("alu_resw", ResultW, 32'h0000_1234);
        check_eq("alu_stall", StallM, 32'd0);
        check_eq("alu_req", dmem_if.DMemReq, 32'd0);
        step();
        check_eq("bub_regw", RegWriteW, 32'd0);
        check_eq("bub_rdw", RDW, 32'd3);
        check_eq("bub_resw", ResultW, 32'h0000_1234);

        // Load with three waiting cycles: stall spans four cycles
        ValidM = 1'b1; MemReadM = 1'b1; ResultSrcM = 1'b1; RegWriteM = 1'b1;
        RDM = 5'd5; ALUResultM = 32'h0000_0040;
        mem_txn("load", 32'h0000_0040, 1'b0, 32'h0, 32'hDEAD_BEEF, 3);
        check_eq("load_regw", RegWriteW, 32'd1);
        check_eq("load_rdw", RDW, 32'd5);
        check_eq("load_resw", ResultW, 32'hDEAD_BEEF);

        // Stray ack while idle is ignored
        dmem_if.DMemAck = 1'b1;
        step();
        dmem_if.DMemAck = 1'b0;
        check_eq("stray_regw", RegWriteW, 32'd0);
        check_eq("stray_req", dmem_if.DMemReq, 32'd0);
        check_eq("stray_stall", StallM, 32'd0);

        // Load with ResultSrcM = 0 writes back the address
        ValidM = 1'b1; MemReadM = 1'b1; RegWriteM = 1'b1; RDM = 5'd4; ALUResultM = 32'h0000_0044;
        mem_txn("ldalu", 32'h0000_0044, 1'b0, 32'h0, 32'h0000_0099, 0);
        check_eq("ldalu_resw", ResultW, 32'h0000_0044);
        check_eq("ldalu_rdw", RDW, 32'd4);

        // Push then pop
        ValidM = 1'b1; PushM = 1'b1; WriteDataM = 32'hA5A5_A5A5;
        mem_txn("push", 32'h0000_0FFC, 1'b1, 32'hA5A5_A5A5, 32'h0, 1);
        check_eq("push_regw", RegWriteW, 32'd0);
        check_eq("push_sp", SPOut, 32'h0000_0FFC);
        ValidM = 1'b1; PopM = 1'b1; RDM = 5'd7;
        mem_txn("pop", 32'h0000_0FFC, 1'b0, 32'h0, 32'hA5A5_A5A5, 0);
        check_eq("pop_regw", RegWriteW, 32'd1);
        check_eq("pop_rdw", RDW, 32'd7);
        check_eq("pop_resw", ResultW, 32'hA5A5_A5A5);
        check_eq("pop_sp", SPOut, 32'h0000_1000);

        // Pop on empty stack faults
        ValidM = 1'b1; PopM = 1'b1; RDM = 5'd9;
        step();
        clear_m();
        check_eq("empty_fault", StackFaultW, 32'd1);
        check_eq("empty_req", dmem_if.DMemReq, 32'd0);
        check_eq("empty_stall", StallM, 32'd0);
        check_eq("empty_regw", RegWriteW, 32'd0);
        check_eq("empty_rdw", RDW, 32'd7);
        check_eq("empty_sp", SPOut, 32'h0000_1000);
        step();
        check_eq("empty_fault_end", StackFaultW, 32'd0);

        // Fill the two-word stack, third push faults
        ValidM = 1'b1; PushM = 1'b1; WriteDataM = 32'h0000_0011;
        mem_txn("fill1", 32'h0000_0FFC, 1'b1, 32'h0000_0011, 32'h0, 0);
        ValidM = 1'b1; PushM = 1'b1; WriteDataM = 32'h0000_0022;
        mem_txn("fill2", 32'h0000_0FF8, 1'b1, 32'h0000_0022, 32'h0, 0);
        check_eq("fill_sp", SPOut, 32'h0000_0FF8);
        ValidM = 1'b1; PushM = 1'b1; WriteDataM = 32'h0000_0033;
        step();
        clear_m();
        check_eq("full_fault", StackFaultW, 32'd1);
        check_eq("full_req", dmem_if.DMemReq, 32'd0);
        check_eq("full_regw", RegWriteW, 32'd0);
        check_eq("full_sp", SPOut, 32'h0000_0FF8);
        step();
        check_eq("full_fault_end", StackFaultW, 32'd0);

        // Illegal combinations
        ValidM = 1'b1; PushM = 1'b1; PopM = 1'b1;
        step();
        clear_m();
        check_eq("pushpop_fault", StackFaultW, 32'd1);
        check_eq("pushpop_req", dmem_if.DMemReq, 32'd0);
        ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b1; ALUResultM = 32'h0000_0010;
        step();
        clear_m();
        check_eq("rdwr_fault", StackFaultW, 32'd1);
        check_eq("rdwr_req", dmem_if.DMemReq, 32'd0);
        ValidM = 1'b1; PopM = 1'b1; MemReadM = 1'b1;
        step();
        clear_m();
        check_eq("poprd_fault", StackFaultW, 32'd1);
        check_eq("poprd_sp", SPOut, 32'h0000_0FF8);

        // Store
        ValidM = 1'b1; MemWriteM = 1'b1; ALUResultM = 32'h0000_0080; WriteDataM = 32'h0000_0055;
        mem_txn("store", 32'h0000_0080, 1'b1, 32'h0000_0055, 32'h0, 2);
        check_eq("store_regw", RegWriteW, 32'd0);

        // Reset during an outstanding access, then a late ack
        ValidM = 1'b1; MemReadM = 1'b1; RegWriteM = 1'b1; ResultSrcM = 1'b1;
        RDM = 5'd6; ALUResultM = 32'h0000_0100;
        step();
        check_eq("rmid_req", dmem_if.DMemReq, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_m();
        check_eq("rmid_req_off", dmem_if.DMemReq, 32'd0);
        check_eq("rmid_stall", StallM, 32'd0);
        check_eq("rmid_sp", SPOut, 32'h0000_1000);
        dmem_if.DMemAck = 1'b1; dmem_if.DMemRData = 32'h0000_0077;
        step();
        dmem_if.DMemAck = 1'b0;
        check_eq("late_regw", RegWriteW, 32'd0);
        check_eq("late_resw", ResultW, 32'h0);
        check_eq("late_req", dmem_if.DMemReq, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
